// File: rtl/a2bus_dma_ctrl.sv
// Apple II bus-master DMA sequencer: acquires the bus via /DMA and runs one
// phi0-aligned bus cycle per single-byte request, with bounded tenure length.
module a2bus_dma_ctrl #(
    parameter int MAX_BURST   = 8,
    parameter int WDATA_COUNT = 4,
    parameter int RDATA_COUNT = 15
) (
    input  logic        clk_logic_i,
    input  logic        system_reset_n_i,
    input  logic        phi0_i,
    input  logic        phi1_posedge_i,
    input  logic        phi0_posedge_i,
    input  logic        phi0_negedge_i,
    input  logic        enable_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rw_n_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    input  logic        a2_dma_in_n_i,
    output logic        a2_dma_out_n_o,
    output logic        a2_dma_n_o,
    output logic [15:0] a2_a_o,
    output logic        a2_a_oe_o,
    output logic        a2_rw_n_o,
    output logic [7:0]  a2_d_o,
    output logic        a2_d_oe_o,
    input  logic [7:0]  a2_d_i,
    output logic        busy_o
);

    localparam logic [5:0] L_MAX  = 6'(MAX_BURST);
    localparam logic [5:0] L_WCNT = 6'(WDATA_COUNT);
    localparam logic [5:0] L_RCNT = 6'(RDATA_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_XFER, S_RELEASE} state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt, r_burst, w_burst_inc;
    logic        r_act;
    logic [15:0] r_addr;
    logic        r_rw_n;
    logic [7:0]  r_wdata, r_rdata;
    logic        w_start, w_to_rel, w_done, w_can_go, w_in_xfer;

    assign w_can_go    = enable_i & req_valid_i;
    assign w_in_xfer   = (r_state == S_XFER);
    assign w_done      = w_in_xfer & r_act & phi0_negedge_i;
    assign w_burst_inc = r_burst + 6'd1;

    // r_act marks a bus cycle in flight; with r_act low in XFER we hold the
    // address bus between back-to-back transfers and wait for phi1.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_to_rel    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (phi1_posedge_i & w_can_go & a2_dma_in_n_i)
                    w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (phi1_posedge_i) begin
                    if (w_can_go) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_XFER;
                    end else begin
                        w_to_rel = 1'b1;
                    end
                end
            end
            S_XFER: begin
                if (w_done) begin
                    if ((w_burst_inc == L_MAX) | ~w_can_go)
                        w_to_rel = 1'b1;
                end else if (~r_act & phi1_posedge_i) begin
                    if (w_can_go) w_start  = 1'b1;
                    else          w_to_rel = 1'b1;
                end
            end
            S_RELEASE: begin
                if (phi1_posedge_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_to_rel) w_state_nxt = S_RELEASE;
    end

    always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
        if (!system_reset_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_burst <= '0;
            r_act   <= 1'b0;
            r_addr  <= '0;
            r_rw_n  <= 1'b1;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (phi1_posedge_i | phi0_posedge_i) r_cnt <= '0;
            else if (r_cnt != 6'd63)             r_cnt <= r_cnt + 6'd1;

            if (w_start)     r_act <= 1'b1;
            else if (w_done) r_act <= 1'b0;

            if (w_to_rel)    r_burst <= '0;
            else if (w_done) r_burst <= w_burst_inc;

            if (w_start) begin
                r_addr  <= req_addr_i;
                r_rw_n  <= req_rw_n_i;
                r_wdata <= req_wdata_i;
            end

            if (w_in_xfer & r_act & r_rw_n & phi0_i & ~phi0_posedge_i & (r_cnt == L_RCNT))
                r_rdata <= a2_d_i;
        end
    end

    // The strobe cycles are masked: the counter is stale on phi0 rising and
    // data must already be off the bus in the phi0 falling cycle.
    assign a2_d_oe_o = w_in_xfer & r_act & ~r_rw_n & phi0_i & ~phi0_posedge_i
                       & ~phi0_negedge_i & (r_cnt >= L_WCNT);

    assign req_ready_o    = w_start;
    assign rsp_valid_o    = w_done;
    assign rsp_rdata_o    = r_rdata;
    assign a2_a_oe_o      = w_in_xfer;
    assign a2_a_o         = r_addr;
    assign a2_rw_n_o      = r_rw_n;
    assign a2_d_o         = r_wdata;
    assign a2_dma_n_o     = ~((r_state == S_ARM) | w_in_xfer);
    assign a2_dma_out_n_o = (r_state == S_IDLE) ? a2_dma_in_n_i : 1'b0;
    assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_a2bus_dma_ctrl.sv
// Bench for a2bus_dma_ctrl: synthetic phi0/phi1 timing, a request queue and a
// transaction-level scoreboard sampled on the falling clock edge.
module tb_a2bus_dma_ctrl;

    localparam int P    = 52;   // clk_logic cycles per bus cycle
    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        rst_n, phi0, phi1_pos, phi0_pos, phi0_neg;
    logic        enable, req_valid, req_ready, req_rw_n;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        dma_in_n, dma_out_n, dma_n;
    logic [15:0] a_o;
    logic        a_oe, rw_n_o;
    logic [7:0]  d_o;
    logic        d_oe;
    logic [7:0]  d_i;
    logic        busy;

    a2bus_dma_ctrl #(.MAX_BURST(MAXB), .WDATA_COUNT(4), .RDATA_COUNT(15)) dut (
        .clk_logic_i(clk), .system_reset_n_i(rst_n), .phi0_i(phi0),
        .phi1_posedge_i(phi1_pos), .phi0_posedge_i(phi0_pos), .phi0_negedge_i(phi0_neg),
        .enable_i(enable), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_rw_n_i(req_rw_n), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .a2_dma_in_n_i(dma_in_n), .a2_dma_out_n_o(dma_out_n), .a2_dma_n_o(dma_n),
        .a2_a_o(a_o), .a2_a_oe_o(a_oe), .a2_rw_n_o(rw_n_o), .a2_d_o(d_o),
        .a2_d_oe_o(d_oe), .a2_d_i(d_i), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw_n;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    req_t       pend_q[$];
    req_t       cur;
    bit         have_cur = 0;
    int         ten_q[$];
    int         ten_cnt = 0, n_ready = 0, n_rsp = 0;
    int         cyc = 0, bt = P - 1;
    int         fall_cyc = 0, rise_cyc = 0;
    bit         seen_rise = 0, mon_en = 0, req_en = 1, fix_en = 0;
    logic       prev_dma = 1'b1;
    logic [7:0] cyc_data = 8'h00, fix_val = 8'h00;
    int         n_chk = 0, n_pass = 0;

    // Bus timing: phi1 rises at bt 0, phi0 rises at bt 26, phi0 falling strobe at bt 51.
    // Bus data is valid only in a window around the expected sample point.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bt       = (bt + 1) % P;
        phi1_pos = (bt == 0);
        phi0_pos = (bt == 26);
        phi0_neg = (bt == 51);
        phi0     = (bt >= 26);
        if (bt == 0) cyc_data = fix_en ? fix_val : 8'($urandom);
        d_i       = (bt >= 38 && bt <= 46) ? cyc_data : ~cyc_data;
        req_valid = req_en && (pend_q.size() > 0);
        if (pend_q.size() > 0) begin
            req_rw_n  = pend_q[0].rw_n;
            req_addr  = pend_q[0].addr;
            req_wdata = pend_q[0].wdata;
        end
        #1;
    endtask

    task automatic push_req(input logic rw, input logic [15:0] a, input logic [7:0] d);
        req_t r;
        r.rw_n = rw; r.addr = a; r.wdata = d;
        pend_q.push_back(r);
    endtask

    task automatic clear_stats();
        n_ready = 0; n_rsp = 0; ten_q.delete();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int k = 0;
        while ((pend_q.size() > 0 || have_cur || busy !== 1'b0) && k < budget) begin
            tick();
            k++;
        end
        ok = (k < budget);
    endtask

    // Scoreboard: expectations come from the bus phase and the accepted request.
    initial forever begin
        bit exp_rsp, exp_doe;
        @(negedge clk);
        if (mon_en) begin
            exp_rsp = have_cur && bt == 51;
            exp_doe = have_cur && !cur.rw_n && bt >= 31 && bt <= 50;
            n_chk++; if (rsp_valid !== exp_rsp) $display("FAIL rsp_valid bt=%0d got %b want %b", bt, rsp_valid, exp_rsp); else n_pass++;
            n_chk++; if (d_oe !== exp_doe) $display("FAIL d_oe bt=%0d got %b want %b", bt, d_oe, exp_doe); else n_pass++;
            if (bt != 0) begin
                n_chk++; if (a_oe !== have_cur) $display("FAIL a_oe bt=%0d got %b want %b", bt, a_oe, have_cur); else n_pass++;
            end
            if (have_cur && bt != 0) begin
                n_chk++; if ({a_o, rw_n_o} !== {cur.addr, cur.rw_n}) $display("FAIL addr_rw got %h/%b want %h/%b", a_o, rw_n_o, cur.addr, cur.rw_n); else n_pass++;
            end
            if (exp_doe) begin
                n_chk++; if (d_o !== cur.wdata) $display("FAIL wdata got %h want %h", d_o, cur.wdata); else n_pass++;
            end
            if (rsp_valid && have_cur) begin
                if (cur.rw_n) begin
                    n_chk++; if (rsp_rdata !== cyc_data) $display("FAIL rdata got %h want %h", rsp_rdata, cyc_data); else n_pass++;
                end
                n_rsp++; ten_cnt++; have_cur = 0;
            end
            if (req_ready) begin
                n_chk++; if (!(bt == 0 && req_valid)) $display("FAIL ready_timing bt=%0d valid=%b want bt=0 valid=1", bt, req_valid); else n_pass++;
                if (ten_cnt == 0) begin
                    n_chk++; if (cyc - fall_cyc != P - 1) $display("FAIL arm_len got %0d want %0d", cyc - fall_cyc, P - 1); else n_pass++;
                end
                if (pend_q.size() == 0) begin
                    n_chk++; $display("FAIL ready_empty got ready with no request want none");
                end else begin
                    cur = pend_q.pop_front(); have_cur = 1; n_ready++;
                end
            end
            if (prev_dma === 1'b1 && dma_n === 1'b0) begin
                fall_cyc = cyc;
                n_chk++; if (bt != 1) $display("FAIL dma_fall bt got %0d want 1", bt); else n_pass++;
                if (seen_rise) begin
                    n_chk++; if (cyc - rise_cyc < P) $display("FAIL dma_gap got %0d want >=%0d", cyc - rise_cyc, P); else n_pass++;
                end
            end
            if (prev_dma === 1'b0 && dma_n === 1'b1) begin
                ten_q.push_back(ten_cnt); ten_cnt = 0; rise_cyc = cyc; seen_rise = 1;
            end
            if (dma_n === 1'b0) begin
                n_chk++; if (dma_out_n !== 1'b0) $display("FAIL dma_out_held got %b want 0", dma_out_n); else n_pass++;
            end
            prev_dma = dma_n;
        end
    end

    task automatic test_reset();
        rst_n = 0; enable = 0; dma_in_n = 1; req_valid = 0; req_rw_n = 1;
        req_addr = '0; req_wdata = '0; d_i = '0;
        phi0 = 0; phi1_pos = 0; phi0_pos = 0; phi0_neg = 0;
        repeat (3) tick();
        n_chk++; if (dma_n !== 1'b1)   $display("FAIL rst_dma_n got %b want 1", dma_n); else n_pass++;
        n_chk++; if (dma_out_n !== 1'b1) $display("FAIL rst_dma_out got %b want 1", dma_out_n); else n_pass++;
        n_chk++; if ({a_oe, d_oe} !== 2'b00) $display("FAIL rst_oe got %b want 00", {a_oe, d_oe}); else n_pass++;
        n_chk++; if ({req_ready, rsp_valid} !== 2'b00) $display("FAIL rst_hs got %b want 00", {req_ready, rsp_valid}); else n_pass++;
        n_chk++; if (rsp_rdata !== 8'h00) $display("FAIL rst_rdata got %h want 00", rsp_rdata); else n_pass++;
        n_chk++; if ({a_o, d_o} !== 24'h0) $display("FAIL rst_bus got %h want 0", {a_o, d_o}); else n_pass++;
        n_chk++; if (rw_n_o !== 1'b1) $display("FAIL rst_rw got %b want 1", rw_n_o); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        dma_in_n = 0; #1;
        n_chk++; if (dma_out_n !== 1'b0) $display("FAIL rst_chain got %b want 0", dma_out_n); else n_pass++;
        dma_in_n = 1;
        rst_n = 1; enable = 1;
        repeat (2 * P) tick();
        mon_en = 1;
    endtask

    task automatic test_single_read();
        bit ok;
        clear_stats(); fix_en = 1; fix_val = 8'h5A;
        push_req(1'b1, 16'hC0F0, 8'h00);
        wait_idle(6 * P, ok);
        fix_en = 0;
        n_chk++; if (!ok) $display("FAIL rd_timeout got busy want idle"); else n_pass++;
        n_chk++; if ({n_ready, n_rsp} !== {32'd1, 32'd1}) $display("FAIL rd_count got %0d/%0d want 1/1", n_ready, n_rsp); else n_pass++;
        n_chk++; if (rsp_rdata !== 8'h5A) $display("FAIL rd_data got %h want 5a", rsp_rdata); else n_pass++;
        n_chk++; if (ten_q.size() != 1 || ten_q[0] != 1) $display("FAIL rd_tenure got %0d tenures want one of 1", ten_q.size()); else n_pass++;
        n_chk++; if (dma_n !== 1'b1) $display("FAIL rd_dma_end got %b want 1", dma_n); else n_pass++;
    endtask

    task automatic test_single_write();
        bit ok;
        clear_stats();
        push_req(1'b0, 16'h2000, 8'hA5);
        wait_idle(6 * P, ok);
        n_chk++; if (!ok) $display("FAIL wr_timeout got busy want idle"); else n_pass++;
        n_chk++; if ({n_ready, n_rsp} !== {32'd1, 32'd1}) $display("FAIL wr_count got %0d/%0d want 1/1", n_ready, n_rsp); else n_pass++;
        n_chk++; if (rsp_rdata !== 8'h5A) $display("FAIL wr_rdata_hold got %h want 5a", rsp_rdata); else n_pass++;
        n_chk++; if (dma_n !== 1'b1) $display("FAIL wr_dma_end got %b want 1", dma_n); else n_pass++;
    endtask

    // Runs n queued requests and checks tenure sizes against min(remaining, MAXB) splits.
    task automatic run_batch(input int n, input bit rand_rw, input string nm);
        bit ok;
        int rem, exp_q[$];
        clear_stats();
        for (int i = 0; i < n; i++)
            push_req(rand_rw ? 1'($urandom) : 1'b1, 16'($urandom), 8'($urandom));
        wait_idle(n * 3 * P + 8 * P, ok);
        n_chk++; if (!ok) $display("FAIL %s_timeout got busy want idle", nm); else n_pass++;
        n_chk++; if (n_ready != n || n_rsp != n) $display("FAIL %s_count got %0d/%0d want %0d/%0d", nm, n_ready, n_rsp, n, n); else n_pass++;
        rem = n;
        while (rem > 0) begin
            exp_q.push_back(rem > MAXB ? MAXB : rem);
            rem -= (rem > MAXB ? MAXB : rem);
        end
        n_chk++; if (ten_q.size() != exp_q.size()) $display("FAIL %s_ntenure got %0d want %0d", nm, ten_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < ten_q.size(); i++) begin
            n_chk++; if (ten_q[i] != exp_q[i]) $display("FAIL %s_tenure%0d got %0d want %0d", nm, i, ten_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        run_batch(20, 1'b0, "b2b");
    endtask

    task automatic test_random();
        run_batch(12, 1'b1, "rand");
    endtask

    task automatic test_chain_blocked();
        bit ok;
        int k;
        clear_stats();
        dma_in_n = 0;
        push_req(1'b1, 16'h1234, 8'h00);
        repeat (3 * P) tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL chain_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (dma_n !== 1'b1) $display("FAIL chain_dma got %b want 1", dma_n); else n_pass++;
        n_chk++; if (dma_out_n !== 1'b0) $display("FAIL chain_out got %b want 0", dma_out_n); else n_pass++;
        n_chk++; if (n_ready != 0) $display("FAIL chain_ready got %0d want 0", n_ready); else n_pass++;
        while (bt != 10) tick();
        dma_in_n = 1;
        k = 0;
        while (busy !== 1'b1 && k < 2 * P) begin tick(); k++; end
        n_chk++; if (busy !== 1'b1 || bt != 1) $display("FAIL chain_arm got busy=%b bt=%0d want busy=1 bt=1", busy, bt); else n_pass++;
        wait_idle(6 * P, ok);
        n_chk++; if (!ok || n_rsp != 1) $display("FAIL chain_done got ok=%b rsp=%0d want 1/1", ok, n_rsp); else n_pass++;
    endtask

    task automatic test_enable_drop();
        int k;
        clear_stats();
        for (int i = 0; i < 3; i++) push_req(1'b0, 16'h3000 + 16'(i), 8'($urandom));
        k = 0;
        while (n_ready == 0 && k < 4 * P) begin tick(); k++; end
        while (bt != 35 && k < 6 * P) begin tick(); k++; end
        n_chk++; if (k >= 6 * P) $display("FAIL endrop_start got timeout want ready"); else n_pass++;
        enable = 0;
        repeat (3 * P) tick();
        n_chk++; if (n_ready != 1 || n_rsp != 1) $display("FAIL endrop_count got %0d/%0d want 1/1", n_ready, n_rsp); else n_pass++;
        n_chk++; if ({busy, dma_n} !== 2'b01) $display("FAIL endrop_state got busy=%b dma_n=%b want 0/1", busy, dma_n); else n_pass++;
        n_chk++; if (ten_q.size() != 1 || ten_q[0] != 1) $display("FAIL endrop_tenure got %0d tenures want one of 1", ten_q.size()); else n_pass++;
        pend_q.delete();
        enable = 1;
        tick();
    endtask

    task automatic test_reset_mid();
        int k = 0;
        clear_stats();
        push_req(1'b0, 16'h4000, 8'h3C);
        while (d_oe !== 1'b1 && k < 4 * P) begin tick(); k++; end
        n_chk++; if (d_oe !== 1'b1) $display("FAIL rmid_reach got d_oe=%b want 1", d_oe); else n_pass++;
        mon_en = 0;
        rst_n = 0; #1;
        n_chk++; if ({a_oe, d_oe} !== 2'b00) $display("FAIL rmid_oe got %b want 00", {a_oe, d_oe}); else n_pass++;
        n_chk++; if (dma_n !== 1'b1) $display("FAIL rmid_dma got %b want 1", dma_n); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
        pend_q.delete(); have_cur = 0; ten_cnt = 0; prev_dma = 1'b1;
        repeat (3) tick();
        rst_n = 1;
        repeat (2 * P) tick();
        n_chk++; if ({busy, dma_n, a_oe} !== 3'b010) $display("FAIL rmid_after got %b want 010", {busy, dma_n, a_oe}); else n_pass++;
        mon_en = 1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_chain_blocked();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/a2bus_dma_ctrl.md
Name: a2bus_dma_ctrl

Overview:
- Apple II bus-master sequencer. Takes single-byte read/write requests from internal requesters, acquires the bus through /DMA, and executes one Apple bus cycle per request.
- Address and data are aligned to the phi0/phi1 strobes from the a2bus timing block.
- Arbitrates with other slots via the DMA daisy chain.
- Bounds burst length so the host CPU is never starved.

Parameters:
- MAX_BURST, 8: maximum consecutive transfers per bus tenure (1..63).
- WDATA_COUNT, 4: clk_logic cycles after phi0 rising before write data is driven.
- RDATA_COUNT, 15: clk_logic cycles after phi0 rising at which read data is sampled.

Ports:
- clk_logic_i  in  1  logic clock (54 MHz).
- system_reset_n_i  in  1  reset; asynchronous, active-low.
- phi0_i  in  1  phi0 level from a2bus timing.
- phi1_posedge_i  in  1  one-cycle strobe, phi1 rising.
- phi0_posedge_i  in  1  one-cycle strobe, phi0 rising.
- phi0_negedge_i  in  1  one-cycle strobe, phi0 falling.
- enable_i  in  1  block may request the bus.
- req_valid_i  in  1  request pending.
- req_ready_o  out  1  request accepted this cycle.
- req_rw_n_i  in  1  1 = read, 0 = write.
- req_addr_i  in  16  transfer address.
- req_wdata_i  in  8  write data.
- rsp_valid_o  out  1  one-cycle pulse, transfer complete.
- rsp_rdata_o  out  8  read data (held until next read).
- a2_dma_in_n_i  in  1  daisy-chain priority in (1 = chain free).
- a2_dma_out_n_o  out  1  daisy-chain priority out.
- a2_dma_n_o  out  1  /DMA to host (0 = asserted).
- a2_a_o  out  16  bus address.
- a2_a_oe_o  out  1  address and R/W drive enable.
- a2_rw_n_o  out  1  bus R/W.
- a2_d_o  out  8  bus data.
- a2_d_oe_o  out  1  data drive enable.
- a2_d_i  in  8  bus data in.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: a2_dma_n_o = 1; a2_dma_out_n_o follows a2_dma_in_n_i; all oe = 0; req_ready_o = 0; rsp_valid_o = 0; rsp_rdata_o = 0; a2_a_o = 0; a2_d_o = 0; a2_rw_n_o = 1; state = IDLE; burst count = 0.
- Phase counter:
  - 6-bit, cleared on phi1_posedge and phi0_posedge.
  - Increments otherwise; saturates at 63.
- IDLE:
  - Condition to leave: enable_i & req_valid_i & a2_dma_in_n_i.
  - On phi1_posedge with that condition true: go to ARM, assert a2_dma_n_o = 0, force a2_dma_out_n_o = 0.
  - In every state other than IDLE, a2_dma_out_n_o = 0.
- ARM: wait one full bus cycle for the CPU to release the bus. At the next phi1_posedge go to XFER.
- XFER:
  - Entry on phi1_posedge. req_ready_o pulses in that cycle if req_valid_i = 1; capture addr, rw_n, wdata.
  - If req_valid_i = 0 at entry, go to RELEASE instead.
  - From entry onward, a2_a_oe_o = 1 and a2_a_o / a2_rw_n_o are driven with the captured values.
  - Write: a2_d_oe_o = 1 from phi0 phase count == WDATA_COUNT until phi0_negedge, inclusive of the cycle before the strobe; deasserted in the phi0_negedge cycle.
  - Read: rsp_rdata_o <= a2_d_i when phi0_i & count == RDATA_COUNT.
  - On phi0_negedge: rsp_valid_o pulses; burst count increments.
  - After that, go to RELEASE if burst count == MAX_BURST, enable_i = 0, or req_valid_i = 0; otherwise to XFER at the next phi1_posedge. a2_a_oe_o stays asserted between back-to-back transfers.
- RELEASE:
  - In the RELEASE entry cycle: a2_a_oe_o = 0, a2_d_oe_o = 0, a2_dma_n_o = 1; burst count cleared.
  - Hold one full bus cycle, so the CPU receives at least one cycle. At the next phi1_posedge go to IDLE, where re-arm is evaluated on the following phi1_posedge.
- enable_i deasserted mid-XFER: the current transfer completes normally, then RELEASE. It never truncates a bus cycle.
- a2_dma_in_n_i falling while ARM or XFER: ignored (chain already held). While IDLE: blocks arming.
- Requests are never accepted outside the XFER entry cycle; req_ready_o is never asserted without req_valid_i.
- Async reset mid-transfer: all drivers and /DMA release immediately.

Test Plan:
- Single read at 0xC0F0, bus data 0x5A → /DMA low one cycle before XFER; a2_a_o = 0xC0F0; a2_rw_n_o = 1; rsp_rdata_o = 0x5A; one rsp_valid pulse; RELEASE, then IDLE, a2_dma_n_o = 1.
- Single write 0x2000 ← 0xA5 → a2_d_oe_o high from phi0 count 4 until phi0_negedge, a2_d_o = 0xA5, a2_rw_n_o = 0; one rsp_valid pulse.
- 20 back-to-back reads, MAX_BURST = 8 → tenures of 8, 8, 4 transfers; /DMA high at least one full bus cycle between tenures; 20 ready pulses, 20 rsp pulses.
- a2_dma_in_n_i = 0 with req_valid_i = 1 → stays IDLE; a2_dma_n_o = 1; a2_dma_out_n_o = 0 (follows input). Releasing the input → arms on the next phi1_posedge.
- enable_i dropped during a write's phi0 → that write completes with a rsp pulse, then RELEASE; no further req_ready.
- system_reset_n_i pulsed low mid-XFER → all oe = 0 and a2_dma_n_o = 1 asynchronously; state IDLE after reset release.
